// File: rtl/capture_pkg.sv
// Shared types and defaults for the capture sequencer.
// State encoding plus default buffer geometry.
package capture_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_CAPTURE = 3'd2,
      S_READY   = 3'd3,
      S_READOUT = 3'd4
   } state_t;

endpackage

// File: rtl/capture_sequencer_if.sv
// Control, sample-source and readout signals of the capture sequencer.
// trig exists only when CAPTURE_TRIG_EN is defined.
interface capture_sequencer_if
   import capture_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) ();
   logic          arm;
`ifdef CAPTURE_TRIG_EN
   logic          trig;
`endif
   logic          s0_stb;
   logic [DW-1:0] s0_data;
   logic          s1_stb;
   logic [DW-1:0] s1_data;
   logic [15:0]   rd_addr;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic          ready;
   logic          overrun;
   logic [AW:0]   level;

   modport master (
`ifdef CAPTURE_TRIG_EN
      output trig,
`endif
      output arm, s0_stb, s0_data, s1_stb, s1_data, rd_addr,
      input  rd_data, busy, ready, overrun, level
   );

   modport slave (
`ifdef CAPTURE_TRIG_EN
      input  trig,
`endif
      input  arm, s0_stb, s0_data, s1_stb, s1_data, rd_addr,
      output rd_data, busy, ready, overrun, level
   );

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: sync write, registered read.
// Only the read register is reset; the array keeps its contents.
module capture_ram #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);
   logic [DW-1:0] mem [0:(2**AW)-1];

   // write port
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // registered read port, updated every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd <= '0;
      else        rd <= mem[ra];
   end

endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: two strobed sources, round-robin into a buffer.
// Optional macro CAPTURE_TRIG_EN: ARMED waits for trig before capturing.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   capture_sequencer_if.slave bus
);
   localparam int            DEPTH = 2 ** AW;
   localparam int            LW    = AW + 1;
   localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
   localparam logic [AW:0]   FULL  = LW'(DEPTH);

   state_t        state, state_nx;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   level;
   logic          overrun;
   logic          gnt;
   logic          h0_v, h1_v;
   logic [DW-1:0] h0_d, h1_d;
   logic          cap, sel1, wr_en, drain0, drain1;
   logic          lost, done, arm_go, trig_ok;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_idx;
   logic          unused_addr;

   assign rd_idx      = bus.rd_addr[AW-1:0];
   assign unused_addr = ^bus.rd_addr[15:AW];

   // arbitration: single valid wins, both valid follows gnt
   always_comb begin
      cap     = (state == S_CAPTURE);
      sel1    = h1_v & (~h0_v | gnt);
      wr_en   = cap & (h0_v | h1_v);
      drain0  = cap & h0_v & ~sel1;
      drain1  = cap & sel1;
      wr_data = sel1 ? h1_d : h0_d;
      done    = wr_en & (wr_ptr == LAST);
      lost    = cap & ((bus.s0_stb & h0_v & ~drain0) |
                       (bus.s1_stb & h1_v & ~drain1));
      arm_go  = bus.arm & (state != S_READOUT);
`ifdef CAPTURE_TRIG_EN
      trig_ok = bus.trig;
`else
      trig_ok = 1'b1;
`endif
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next state; a restart request overrides every other move
   always_comb begin
      state_nx = state;
      if (arm_go) begin
         state_nx = S_ARMED;
      end else begin
         unique case (state)
            S_IDLE:    state_nx = S_IDLE;
            S_ARMED:   if (trig_ok) state_nx = S_CAPTURE;
            S_CAPTURE: if (done) state_nx = S_READY;
            S_READY:   if (rd_idx != '0) state_nx = S_READOUT;
            S_READOUT: if (rd_idx == '0) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
         endcase
      end
   end

   // status outputs decoded from state
   always_comb begin
      bus.busy    = 1'b0;
      bus.ready   = 1'b0;
      bus.level   = level;
      bus.overrun = overrun;
      unique case (1'b1)
         (state == S_ARMED),
         (state == S_CAPTURE): bus.busy  = 1'b1;
         (state == S_READY):   bus.ready = 1'b1;
         default: ;
      endcase
   end

   // source 0 hold register: outside capture it only holds the latest strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h0_v <= 1'b0;
         h0_d <= '0;
      end else if (!cap) begin
         h0_v <= bus.s0_stb;
         if (bus.s0_stb) h0_d <= bus.s0_data;
      end else if (bus.s0_stb && (!h0_v || drain0)) begin
         h0_v <= 1'b1;
         h0_d <= bus.s0_data;
      end else if (drain0) begin
         h0_v <= 1'b0;
      end
   end

   // source 1 hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h1_v <= 1'b0;
         h1_d <= '0;
      end else if (!cap) begin
         h1_v <= bus.s1_stb;
         if (bus.s1_stb) h1_d <= bus.s1_data;
      end else if (bus.s1_stb && (!h1_v || drain1)) begin
         h1_v <= 1'b1;
         h1_d <= bus.s1_data;
      end else if (drain1) begin
         h1_v <= 1'b0;
      end
   end

   // write pointer, fill level, grant and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         gnt     <= 1'b0;
      end else if (arm_go) begin
         wr_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         gnt     <= 1'b0;
      end else if (cap) begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (level != FULL) level <= level + 1'b1;
         end
         if (h0_v && h1_v) gnt <= ~sel1;
         if (lost) overrun <= 1'b1;
      end
   end

   capture_ram #(
      .AW (AW),
      .DW (DW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .wa    (wr_ptr),
      .wd    (wr_data),
      .ra    (rd_idx),
      .rd    (bus.rd_data)
   );

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer (AW=4, DW=16).
// Trigger scenario runs only when CAPTURE_TRIG_EN is defined.
module tb_capture_sequencer;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int DEPTH = 16;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic [DW-1:0] exp_mem [0:DEPTH-1];

   capture_sequencer_if #(.AW(AW), .DW(DW)) bus ();

   capture_sequencer #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic stb_off();
      bus.s0_stb = 1'b0;
      bus.s1_stb = 1'b0;
   endtask

   // returns at the negedge where the DUT has just entered ARMED
   task automatic do_arm();
      bus.arm = 1'b1;
      tick();
      bus.arm = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b ready=%b overrun=%b required 0 0 0",
                  bus.busy, bus.ready, bus.overrun);
      end
      checks++;
      if (bus.level !== 5'd0 || bus.rd_data !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: level=%0d rd_data=%h required 0 0000",
                  bus.level, bus.rd_data);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_interleave();
      int n;
      int cyc;
      do_arm();
      n = 0;
      cyc = 0;
      while (bus.ready !== 1'b1 && cyc < 64) begin
         bus.s0_stb  = 1'b1;
         bus.s1_stb  = 1'b1;
         bus.s0_data = 16'(32'h1000 + n);
         bus.s1_data = 16'(32'h2000 + n);
         n++;
         tick();
         cyc++;
      end
      stb_off();
      checks++;
      if (bus.ready !== 1'b1 || cyc != 17) begin
         errors++;
         $display("FAIL interleave_done: ready=%b cycles=%0d required 1 17", bus.ready, cyc);
      end
      checks++;
      if (bus.overrun !== 1'b1 || bus.level !== 5'd16 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL interleave_status: overrun=%b level=%0d busy=%b required 1 16 0",
                  bus.overrun, bus.level, bus.busy);
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (k == 0)          exp_mem[k] = 16'h1000;
         else if (k % 2 == 0) exp_mem[k] = 16'(32'h1000 + k - 1);
         else                 exp_mem[k] = 16'(32'h2000 + k - 1);
      end
   endtask

   task automatic test_single_source();
      int n;
      int cyc;
      do_arm();
      n = 0;
      cyc = 0;
      while (bus.ready !== 1'b1 && cyc < 80) begin
         bus.s0_stb  = (cyc % 2 == 0);
         bus.s0_data = 16'(32'h3000 + n);
         if (cyc % 2 == 0) n++;
         tick();
         cyc++;
      end
      stb_off();
      checks++;
      if (bus.ready !== 1'b1 || cyc != 32) begin
         errors++;
         $display("FAIL single_done: ready=%b cycles=%0d required 1 32", bus.ready, cyc);
      end
      checks++;
      if (bus.overrun !== 1'b0 || bus.level !== 5'd16) begin
         errors++;
         $display("FAIL single_status: overrun=%b level=%0d required 0 16",
                  bus.overrun, bus.level);
      end
      for (int k = 0; k < DEPTH; k++) exp_mem[k] = 16'(32'h3000 + k);
   endtask

   task automatic test_readout();
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr = 16'(a);
         bus.arm = (a == 8);
         tick();
         bus.arm = 1'b0;
         checks++;
         if (bus.rd_data !== exp_mem[a]) begin
            errors++;
            $display("FAIL readout_word[%0d]: got %h required %h", a, bus.rd_data, exp_mem[a]);
         end
         if (a == 0) begin
            checks++;
            if (bus.ready !== 1'b1) begin
               errors++;
               $display("FAIL readout_hold_ready: ready=%b required 1", bus.ready);
            end
         end
         if (a == 8) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
               errors++;
               $display("FAIL arm_in_readout: busy=%b ready=%b required 0 0",
                        bus.busy, bus.ready);
            end
         end
      end
      bus.rd_addr = 16'h0;
      tick();
      checks++;
      if (bus.rd_data !== exp_mem[0] || bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL readout_wrap: rd_data=%h ready=%b required %h 0",
                  bus.rd_data, bus.ready, exp_mem[0]);
      end
      do_arm();
      checks++;
      if (bus.busy !== 1'b1 || bus.level !== 5'd0) begin
         errors++;
         $display("FAIL idle_after_wrap: busy=%b level=%0d required 1 0", bus.busy, bus.level);
      end
   endtask

   task automatic test_restart();
      int cyc;
      do_arm();
      cyc = 0;
      while (bus.level !== 5'd7 && cyc < 40) begin
         bus.s0_stb  = 1'b1;
         bus.s1_stb  = 1'b1;
         bus.s0_data = 16'(32'h4000 + cyc);
         bus.s1_data = 16'(32'h5000 + cyc);
         tick();
         cyc++;
      end
      checks++;
      if (bus.level !== 5'd7 || bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL restart_pre: level=%0d overrun=%b required 7 1", bus.level, bus.overrun);
      end
      do_arm();
      stb_off();
      checks++;
      if (bus.level !== 5'd0 || bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_armed: level=%0d overrun=%b busy=%b required 0 0 1",
                  bus.level, bus.overrun, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_arm();
      cyc = 0;
      while (bus.level !== 5'd5 && cyc < 40) begin
         bus.s0_stb  = 1'b1;
         bus.s0_data = 16'(32'h6000 + cyc);
         tick();
         cyc++;
      end
      checks++;
      if (bus.level !== 5'd5 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: level=%0d busy=%b required 5 1", bus.level, bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.overrun !== 1'b0 ||
          bus.level !== 5'd0 || bus.rd_data !== 16'h0) begin
         errors++;
         $display("FAIL midreset_async: busy=%b ready=%b overrun=%b level=%0d rd_data=%h required all 0",
                  bus.busy, bus.ready, bus.overrun, bus.level, bus.rd_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      stb_off();
      checks++;
      if (bus.busy !== 1'b0 || bus.level !== 5'd0) begin
         errors++;
         $display("FAIL midreset_idle: busy=%b level=%0d required 0 0", bus.busy, bus.level);
      end
   endtask

`ifdef CAPTURE_TRIG_EN
   task automatic test_trigger();
      int bad;
      do_arm();
      bad = 0;
      bus.trig = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.s0_stb  = 1'b1;
         bus.s1_stb  = 1'b1;
         bus.s0_data = 16'(32'h7000 + c);
         bus.s1_data = 16'(32'h8000 + c);
         tick();
         if (bus.level !== 5'd0 || bus.busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL trig_wait: %0d cycles with level!=0 or busy!=1, required 0", bad);
      end
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
      stb_off();
      tick();
      tick();
      checks++;
      if (bus.level !== 5'd2 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL trig_capture: level=%0d overrun=%b required 2 0", bus.level, bus.overrun);
      end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.arm = 1'b0;
`ifdef CAPTURE_TRIG_EN
      bus.trig = 1'b0;
`endif
      bus.s0_stb = 1'b0;
      bus.s1_stb = 1'b0;
      bus.s0_data = '0;
      bus.s1_data = '0;
      bus.rd_addr = '0;
      test_reset();
      test_interleave();
      test_readout();
      test_single_source();
      test_readout();
      test_restart();
`ifdef CAPTURE_TRIG_EN
      test_trigger();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
